// File: rtl/ps2_keyboard_port_pkg.sv
// ps2_keyboard_port_pkg
//   Shared definitions for the PS/2 keyboard port:
//   - Hack key-code constants (non-ASCII keys 128..152)
//   - PS/2 scan-code set 2 prefix bytes
//   - receiver FSM state encoding
//   - odd-parity helper
package ps2_keyboard_port_pkg;

    localparam int KEY_W = 16;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam logic [KEY_W-1:0] KEY_NEWLINE   = 16'd128;
    localparam logic [KEY_W-1:0] KEY_BACKSPACE = 16'd129;
    localparam logic [KEY_W-1:0] KEY_LEFT      = 16'd130;
    localparam logic [KEY_W-1:0] KEY_UP        = 16'd131;
    localparam logic [KEY_W-1:0] KEY_RIGHT     = 16'd132;
    localparam logic [KEY_W-1:0] KEY_DOWN      = 16'd133;
    localparam logic [KEY_W-1:0] KEY_HOME      = 16'd134;
    localparam logic [KEY_W-1:0] KEY_END       = 16'd135;
    localparam logic [KEY_W-1:0] KEY_PGUP      = 16'd136;
    localparam logic [KEY_W-1:0] KEY_PGDN      = 16'd137;
    localparam logic [KEY_W-1:0] KEY_INSERT    = 16'd138;
    localparam logic [KEY_W-1:0] KEY_DELETE    = 16'd139;
    localparam logic [KEY_W-1:0] KEY_ESC       = 16'd140;
    localparam logic [KEY_W-1:0] KEY_F1        = 16'd141;
    localparam logic [KEY_W-1:0] KEY_F12       = 16'd152;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2State_t;

    // True when data byte plus parity bit hold an odd number of ones.
    function automatic logic oddParityOk(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_keyboard_port_if.sv
// ps2_keyboard_port_if
//   Keyboard-register side of the PS/2 port.
//   key        : Hack key code of the held key, 0 = none
//   key_strobe : one-cycle pulse whenever key changes
//   frame_err  : one-cycle pulse on a rejected or timed-out frame
//   master = the keyboard port (drives), slave = memory / observer (reads)
interface ps2_keyboard_port_if;
    import ps2_keyboard_port_pkg::*;

    logic [KEY_W-1:0] key;
    logic             key_strobe;
    logic             frame_err;

    modport master (output key, output key_strobe, output frame_err);
    modport slave  (input  key, input  key_strobe, input  frame_err);
endinterface

// File: rtl/ps2_scan_xlate.sv
// ps2_scan_xlate
//   Combinational scan-code set 2 to Hack key-code table.
//   ext      : byte was preceded by the E0 prefix
//   scanCode : scan-code byte
//   code     : Hack key code, 0 for untranslated keys (incl. shift/ctrl/alt)
module ps2_scan_xlate
    import ps2_keyboard_port_pkg::*;
(
    input  logic             ext,
    input  logic [7:0]       scanCode,
    output logic [KEY_W-1:0] code
);

    always_comb begin
        // NOTE: a default on every path keeps this block free of inferred latches.
        code = '0;
        if (ext) begin
            case (scanCode)
                8'h6B:   code = KEY_LEFT;
                8'h75:   code = KEY_UP;
                8'h74:   code = KEY_RIGHT;
                8'h72:   code = KEY_DOWN;
                8'h6C:   code = KEY_HOME;
                8'h69:   code = KEY_END;
                8'h7D:   code = KEY_PGUP;
                8'h7A:   code = KEY_PGDN;
                8'h70:   code = KEY_INSERT;
                8'h71:   code = KEY_DELETE;
                default: code = '0;
            endcase
        end else begin
            case (scanCode)
                8'h1C: code = 16'd65;  8'h32: code = 16'd66;  8'h21: code = 16'd67;
                8'h23: code = 16'd68;  8'h24: code = 16'd69;  8'h2B: code = 16'd70;
                8'h34: code = 16'd71;  8'h33: code = 16'd72;  8'h43: code = 16'd73;
                8'h3B: code = 16'd74;  8'h42: code = 16'd75;  8'h4B: code = 16'd76;
                8'h3A: code = 16'd77;  8'h31: code = 16'd78;  8'h44: code = 16'd79;
                8'h4D: code = 16'd80;  8'h15: code = 16'd81;  8'h2D: code = 16'd82;
                8'h1B: code = 16'd83;  8'h2C: code = 16'd84;  8'h3C: code = 16'd85;
                8'h2A: code = 16'd86;  8'h1D: code = 16'd87;  8'h22: code = 16'd88;
                8'h35: code = 16'd89;  8'h1A: code = 16'd90;
                8'h45: code = 16'd48;  8'h16: code = 16'd49;  8'h1E: code = 16'd50;
                8'h26: code = 16'd51;  8'h25: code = 16'd52;  8'h2E: code = 16'd53;
                8'h36: code = 16'd54;  8'h3D: code = 16'd55;  8'h3E: code = 16'd56;
                8'h46: code = 16'd57;
                8'h29: code = 16'd32;
                8'h5A: code = KEY_NEWLINE;
                8'h66: code = KEY_BACKSPACE;
                8'h76: code = KEY_ESC;
                8'h05: code = KEY_F1;  8'h06: code = 16'd142; 8'h04: code = 16'd143;
                8'h0C: code = 16'd144; 8'h03: code = 16'd145; 8'h0B: code = 16'd146;
                8'h83: code = 16'd147; 8'h0A: code = 16'd148; 8'h01: code = 16'd149;
                8'h09: code = 16'd150; 8'h78: code = 16'd151; 8'h07: code = KEY_F12;
                8'h0E: code = 16'd96;  8'h4E: code = 16'd45;  8'h55: code = 16'd61;
                8'h54: code = 16'd91;  8'h5B: code = 16'd93;  8'h4C: code = 16'd59;
                8'h52: code = 16'd39;  8'h41: code = 16'd44;  8'h49: code = 16'd46;
                8'h4A: code = 16'd47;  8'h5D: code = 16'd92;
                default: code = '0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_port.sv
// ps2_keyboard_port
//   PS/2 keyboard receiver feeding the Hack keyboard register (0x6000).
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low
//   ps2_clk  : raw PS/2 clock pad (asynchronous)
//   ps2_data : raw PS/2 data pad (asynchronous)
//   bus      : key / key_strobe / frame_err (master side)
module ps2_keyboard_port
    import ps2_keyboard_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_keyboard_port_if.master   bus
);

    ps2State_t        state, stateNext;
    logic [1:0]       clkSync, dataSync;
    logic             clkPrev;
    logic             fallEdge, bitIn;
    logic [TO_W-1:0]  toCnt;
    logic             timeout;
    logic [2:0]       bitCnt;
    logic [7:0]       shReg;
    logic             parBit;
    logic             extFlag, brkFlag;
    logic             shiftEn, parEn, startErr, stopEdge, byteOk, errEvent;
    logic             isPrefix;
    logic [KEY_W-1:0] code, keyReg, keyNext;
    logic             strobeReg, errReg;

    // Synchronizers reset high so the idle bus never looks like a falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value, forming a real shift chain.
            clkSync  <= {clkSync[0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
            clkPrev  <= clkSync[1];
        end
    end

    assign fallEdge = clkPrev & ~clkSync[1];
    assign bitIn    = dataSync[1];

    // An edge in the same cycle suppresses the timeout.
    assign timeout = (state != IDLE) && !fallEdge &&
                     (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // FSM: next state
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (fallEdge && !bitIn)          stateNext = DATA;
            DATA:    if (fallEdge && bitCnt == 3'd7)  stateNext = PARITY;
            PARITY:  if (fallEdge)                    stateNext = STOP;
            STOP:    if (fallEdge)                    stateNext = IDLE;
            default:                                  stateNext = IDLE;
        endcase
        if (timeout) stateNext = IDLE;
    end

    // FSM: outputs
    always_comb begin
        shiftEn  = (state == DATA)   && fallEdge;
        parEn    = (state == PARITY) && fallEdge;
        startErr = (state == IDLE)   && fallEdge && bitIn;
        stopEdge = (state == STOP)   && fallEdge;
        byteOk   = stopEdge && bitIn && oddParityOk(shReg, parBit);
        errEvent = startErr || (stopEdge && !byteOk) || timeout;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) toCnt <= '0;
        else if (state == IDLE || fallEdge || timeout) toCnt <= '0;
        else toCnt <= toCnt + TO_W'(1);
    end

    // The complete byte sits in shReg during the stop-bit cycle, so it is
    // decoded right away and key lands on the next clock edge.
    ps2_scan_xlate u_xlate (
        .ext      (extFlag),
        .scanCode (shReg),
        .code     (code)
    );

    assign isPrefix = (shReg == SC_EXT) || (shReg == SC_BRK);

    always_comb begin
        keyNext = keyReg;
        if (byteOk && !isPrefix) begin
            if (!brkFlag) begin
                if (code != '0) keyNext = code;
            end else if (code == keyReg) begin
                keyNext = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bitCnt    <= '0;
            shReg     <= '0;
            parBit    <= 1'b0;
            extFlag   <= 1'b0;
            brkFlag   <= 1'b0;
            keyReg    <= '0;
            strobeReg <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            if (state == IDLE && fallEdge) bitCnt <= '0;
            else if (shiftEn)              bitCnt <= bitCnt + 3'd1;
            if (shiftEn) shReg  <= {bitIn, shReg[7:1]};
            if (parEn)   parBit <= bitIn;
            // Prefix flags survive aborted frames; only a decoded key clears them.
            if (byteOk) begin
                if (shReg == SC_EXT)      extFlag <= 1'b1;
                else if (shReg == SC_BRK) brkFlag <= 1'b1;
                else begin
                    extFlag <= 1'b0;
                    brkFlag <= 1'b0;
                end
            end
            keyReg    <= keyNext;
            strobeReg <= (keyNext != keyReg);
            errReg    <= errEvent;
        end
    end

    assign bus.key        = keyReg;
    assign bus.key_strobe = strobeReg;
    assign bus.frame_err  = errReg;

endmodule

// File: tb/tb_ps2_keyboard_port.sv
`timescale 1ns/1ps
module tb_ps2_keyboard_port;

    localparam int HALF = 40;   // 1 MHz system clock, 12.5 kHz PS/2 clock

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stopEdgeCyc = 0;
    int strobeCyc = 0;
    int errSeen = 0;
    int errExp = 0;
    logic [15:0] expQ[$];

    ps2_keyboard_port_if kbIf();

    ps2_keyboard_port dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (kbIf)
    );

    // Standalone translator instance for direct table checks.
    logic        xExt;
    logic [7:0]  xScan;
    logic [15:0] xCode;
    ps2_scan_xlate u_xl (.ext(xExt), .scanCode(xScan), .code(xCode));

    always #500 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every key_strobe must match the next expected key.
    always @(negedge clock) begin
        if (reset) begin
            if (kbIf.frame_err) errSeen++;
            if (kbIf.key_strobe) begin
                strobeCyc = cyc;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected key_strobe: key=%0d", kbIf.key);
                end else begin
                    check("key on strobe", {16'd0, kbIf.key}, {16'd0, expQ.pop_front()});
                end
            end
        end
    end

    task automatic sendFrame(input logic [7:0] b, input bit flipPar, input int nBits);
        logic [10:0] bits;
        logic par;
        par  = (~^b) ^ flipPar;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10) stopEdgeCyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        if (nBits == 11) begin
            ps2_data = 1'b1;
            repeat (HALF) @(negedge clock);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        sendFrame(b, 1'b0, 11);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clock);
        check(name, expQ.size(), 0);
    endtask

    task automatic waitErr(input string name, input int budget);
        for (int i = 0; i < budget && errSeen < errExp; i++) @(negedge clock);
        repeat (4) @(negedge clock);
        check(name, errSeen, errExp);
    endtask

    typedef struct {
        logic        ext;
        logic [7:0]  sc;
        logic [15:0] code;
    } xvec_t;

    xvec_t xv[20] = '{
        '{1'b0, 8'h1C, 16'd65},  '{1'b0, 8'h1A, 16'd90},  '{1'b0, 8'h45, 16'd48},
        '{1'b0, 8'h46, 16'd57},  '{1'b0, 8'h29, 16'd32},  '{1'b0, 8'h5A, 16'd128},
        '{1'b0, 8'h66, 16'd129}, '{1'b1, 8'h6B, 16'd130}, '{1'b1, 8'h72, 16'd133},
        '{1'b1, 8'h71, 16'd139}, '{1'b0, 8'h76, 16'd140}, '{1'b0, 8'h05, 16'd141},
        '{1'b0, 8'h07, 16'd152}, '{1'b0, 8'h83, 16'd147}, '{1'b0, 8'h0E, 16'd96},
        '{1'b0, 8'h5D, 16'd92},  '{1'b0, 8'h12, 16'd0},   '{1'b0, 8'h75, 16'd0},
        '{1'b1, 8'h1C, 16'd0},   '{1'b1, 8'h7D, 16'd136}
    };

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Translator table, directed vectors
        foreach (xv[i]) begin
            xExt  = xv[i].ext;
            xScan = xv[i].sc;
            #1;
            check($sformatf("xlate ext=%0d sc=%02h", xv[i].ext, xv[i].sc), {16'd0, xCode}, {16'd0, xv[i].code});
        end

        // Reset state
        repeat (3) @(negedge clock);
        check("reset key", {16'd0, kbIf.key}, 0);
        check("reset key_strobe", {31'd0, kbIf.key_strobe}, 0);
        check("reset frame_err", {31'd0, kbIf.frame_err}, 0);
        reset = 1'b1;
        repeat (10) @(negedge clock);

        // 'A' make, latency from the stop-bit pad edge
        expQ.push_back(16'd65);
        sendByte(8'h1C);
        drain("A make drained");
        lat = strobeCyc - stopEdgeCyc;
        check("stop-edge to key latency in 3..4", {31'd0, (lat >= 3 && lat <= 4)}, 1);
        check("key after A make", {16'd0, kbIf.key}, 65);

        // Auto-repeat produces no strobe, then release
        sendByte(8'h1C);
        check("key after A repeat", {16'd0, kbIf.key}, 65);
        expQ.push_back(16'd0);
        sendByte(8'hF0);
        sendByte(8'h1C);
        drain("A release drained");

        // Extended up arrow press / release, then keypad 8 (untranslated)
        expQ.push_back(16'd131);
        sendByte(8'hE0);
        sendByte(8'h75);
        drain("up make drained");
        expQ.push_back(16'd0);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        drain("up release drained");
        sendByte(8'h75);
        repeat (10) @(negedge clock);
        check("keypad 8 ignored", {16'd0, kbIf.key}, 0);

        // Roll-over: A held, B pressed, A released, B released
        expQ.push_back(16'd65);
        sendByte(8'h1C);
        expQ.push_back(16'd66);
        sendByte(8'h32);
        sendByte(8'hF0);
        sendByte(8'h1C);
        repeat (10) @(negedge clock);
        check("B held after A release", {16'd0, kbIf.key}, 66);
        expQ.push_back(16'd0);
        sendByte(8'hF0);
        sendByte(8'h32);
        drain("rollover drained");
        check("no frame errors so far", errSeen, 0);

        // Parity error
        errExp++;
        sendFrame(8'h1C, 1'b1, 11);
        waitErr("parity error pulse", 200);
        check("key after parity error", {16'd0, kbIf.key}, 0);

        // Start-bit error: lone falling edge with data high
        errExp++;
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
        waitErr("start error pulse", 200);

        // Timeout: 4 bits then stall
        errExp++;
        sendFrame(8'h29, 1'b0, 4);
        ps2_data = 1'b1;
        waitErr("timeout error pulse", 60000);
        expQ.push_back(16'd32);
        sendByte(8'h29);
        drain("space after timeout drained");
        check("key after timeout recovery", {16'd0, kbIf.key}, 32);
        expQ.push_back(16'd0);
        sendByte(8'hF0);
        sendByte(8'h29);
        expQ.push_back(16'd65);
        sendByte(8'h1C);
        drain("A before reset drained");

        // Asynchronous reset mid-frame
        sendFrame(8'h1C, 1'b0, 5);
        repeat (5) @(negedge clock);
        #100;
        reset = 1'b0;
        #1;
        check("key immediately on reset", {16'd0, kbIf.key}, 0);
        check("strobe during reset", {31'd0, kbIf.key_strobe}, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        expQ.push_back(16'd48);
        sendByte(8'h45);
        drain("digit 0 after reset drained");
        check("key after reset recovery", {16'd0, kbIf.key}, 48);
        repeat (10) @(negedge clock);
        check("total frame errors", errSeen, errExp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_port.md
Name: ps2_keyboard_port

Overview:
- Upstream feeder for the memory-mapped keyboard register at address 24576 (0x6000).
- Receives PS/2 scan-code set 2 frames from a physical keyboard and tracks make/break/extended prefixes.
- Translates scan codes to Hack key codes.
- Holds the code of the currently pressed key on a 16-bit output, 0 when no key is held. Memory loads this output in place of the fixed constant.

Parameters:
TIMEOUT_CYCLES, 50000, max clock cycles between ps2_clk falling edges inside a frame before the frame is aborted
TO_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ps2_clk  input  1  raw PS/2 clock from the pad, asynchronous
ps2_data  input  1  raw PS/2 data from the pad, asynchronous
key  output  16  Hack key code of the held key, 0 = none; drives the keyboard register input
key_strobe  output  1  one-cycle pulse whenever key changes value
frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Reset (reset=0, asynchronous):
  - key=0, key_strobe=0, frame_err=0.
  - FSM to IDLE; prefix flags cleared.
  - Synchronizers set to 1 (bus idle-high).
- Input synchronization:
  - 2-FF synchronizer on each of ps2_clk and ps2_data.
  - A falling edge means the synced ps2_clk was 1 last cycle and is 0 this cycle.
  - Data is sampled from synced ps2_data in the same cycle the edge is detected.
- Frame format: 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge with data=0, go to DATA and set bitcnt=0. On edge with data=1, stay in IDLE and pulse frame_err.
  - DATA: on each edge, shift the bit into shreg[7] (right shift). After the 8th bit, go to PARITY.
  - PARITY: on edge, latch the parity bit and go to STOP.
  - STOP: on edge, check stop=1 and that XOR(data, parity)=1. If both pass, the byte is accepted. Otherwise pulse frame_err and discard. Return to IDLE either way.
- Timeout:
  - The counter runs in every state except IDLE and clears on each edge.
  - On reaching TIMEOUT_CYCLES: pulse frame_err, return to IDLE, discard the partial byte.
  - Prefix flags are kept.
- Byte decode, evaluated in the cycle after an accepted stop bit:
  - 0xE0: set ext flag.
  - 0xF0: set brk flag.
  - Any other byte: look up code = xlate(ext, byte), then clear ext and brk.
    - Make (brk=0) with code≠0: key=code.
    - Break (brk=1) with code==key: key=0.
    - Break of a different key: no change.
    - Untranslated code (0): no change.
- key_strobe asserts in the same cycle key is written, and only if the new value differs from the old.
- Latency: key is valid 1 cycle after the cycle in which the stop-bit edge is detected. That is 3 to 4 clocks after the pad edge.
- Auto-repeat: repeated make codes rewrite the same value, so key_strobe stays low.
- Simultaneous events:
  - Reset dominates everything.
  - If a timeout and an edge land in the same cycle, the edge wins.
- Translation (Hack set):
  - Letters map to uppercase ASCII 65–90.
  - Digits map to 48–57; space to 32.
  - Enter 128, backspace 129.
  - Arrows (ext): left 130, up 131, right 132, down 133.
  - Ext keys: home 134, end 135, pgup 136, pgdn 137, insert 138, delete 139.
  - Esc 140; F1–F12 map to 141–152.
  - Punctuation `-=[];',./\` and backtick map to their unshifted ASCII codes.
  - Everything else maps to 0.
  - Shift, ctrl and alt produce 0 and are ignored.

Decomposition:
- Shared package/header:
  - Hack key-code constants (KEY_NEWLINE=128 … KEY_F12=152).
  - Scan prefixes SC_EXT=8'hE0, SC_BRK=8'hF0.
  - FSM state encodings.
- Sub-module ps2_scan_xlate: purely combinational. Inputs ext and byte[7:0]; output code[15:0]. It is a case table that the bench can also check exhaustively on its own.

Test Plan:
- Send 0x1C ('A' make) at 12.5 kHz PS/2 clock -> key=65 one clock after the stop-bit edge; key_strobe pulses once; frame_err stays 0.
- Send 0x1C, then F0 1C -> key=65, then key=0 after the final byte; two strobes in total.
- Send E0 75 then E0 F0 75 -> key=131 (up), then 0. Send 75 without E0 -> key unchanged (keypad 8 untranslated).
- Hold 'A' (0x1C) and press 'B' (0x32), then release 'A' (F0 1C) -> key goes 65→66 and stays 66; releasing B (F0 32) -> 0.
- Send 0x1C with even parity -> frame_err pulse, key stays 0. Send 4 bits and then stall ps2_clk for more than 50000 cycles -> frame_err at the timeout, FSM in IDLE, and the next clean 0x29 frame gives key=32.
- Assert reset=0 mid-frame after 5 bits while key=65 -> key=0 immediately (asynchronous). After release, a full 0x45 frame gives key=48.
